// File: rtl/dm_pkg.sv
// Shared constants, trace entry layout and helpers for dm_responder.
// The trace entry is packed {pc, addr, data, byteen}, with byteen in the LSBs.
package dm_pkg;

    localparam int unsigned MEM_BYTES     = 32'h3000;
    localparam logic [3:0]  BE_WORD       = 4'b1111;
    localparam logic [3:0]  BE_HALF_LO    = 4'b0011;
    localparam logic [3:0]  BE_HALF_HI    = 4'b1100;

    localparam int unsigned TRACE_ENTRY_W = 100;
    localparam int unsigned TE_BE_LSB     = 0;
    localparam int unsigned TE_DATA_LSB   = 4;
    localparam int unsigned TE_ADDR_LSB   = 36;
    localparam int unsigned TE_PC_LSB     = 68;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_entry_t;

    // Replace the enabled byte lanes of old_word with the matching lanes of wdata.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (byteen[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

    // Naturally aligned word, halfword or byte access.
    function automatic logic align_ok(input logic [3:0] byteen,
                                      input logic [1:0] lo);
        return ((byteen == BE_WORD)    && (lo == 2'b00)) ||
               ((byteen == BE_HALF_LO) && (lo == 2'b00)) ||
               ((byteen == BE_HALF_HI) && (lo == 2'b10)) ||
               (byteen == 4'(4'b0001 << lo));
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// trace_fifo: show-ahead FIFO, synchronous active-high reset.
// Ports: push/din write, pop advances head, dout = head, full/empty flags.
// A push while full is accepted only together with a pop.
module trace_fifo
    import dm_pkg::*;
#(
    parameter int unsigned WIDTH = TRACE_ENTRY_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data memory for the CPU m_data_* bus with a store trace FIFO.
// Ports: m_data_addr/wdata/byteen/m_inst_addr in, m_data_rdata out (combinational,
//   read-before-write); trace_valid/ready handshake with trace_pc/addr/data/byteen
//   head fields; trace_ovf counts stores dropped while the FIFO was full.
// Optional: define DM_ALIGN_CHECK_EN to reject misaligned stores and add the
//   sticky align_fault output.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = MEM_BYTES / 4,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned OVF_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      m_data_addr,
    input  logic [31:0]      m_data_wdata,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_inst_addr,
    output logic [31:0]      m_data_rdata,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic [3:0]       trace_byteen,
`ifdef DM_ALIGN_CHECK_EN
    output logic             align_fault,
`endif
    output logic [OVF_W-1:0] trace_ovf
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);
    localparam int unsigned IDX_W     = 12;

    logic [31:0]              mem_q [MEM_WORDS];
    logic [IDX_W-1:0]         idx;
    logic                     in_range;
    logic [31:0]              rd_word;
    logic [31:0]              merged;
    logic                     store_req;
    logic                     commit;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [OVF_W-1:0]         ovf_q, ovf_d;
    trace_entry_t             entry;
    logic [TRACE_ENTRY_W-1:0] head;

    // Address decode, read port and lane merge.
    always_comb begin
        idx       = m_data_addr[13:2];
        in_range  = (m_data_addr < MEM_LIMIT);
        rd_word   = in_range ? mem_q[idx] : 32'h0;
        merged    = merge_word(rd_word, m_data_wdata, m_data_byteen);
        store_req = (m_data_byteen != 4'b0000) && in_range && !reset;
    end

    assign m_data_rdata = rd_word;

`ifdef DM_ALIGN_CHECK_EN
    logic fault;
    logic align_fault_q, align_fault_d;

    always_comb begin
        fault         = store_req && !align_ok(m_data_byteen, m_data_addr[1:0]);
        commit        = store_req && !fault;
        align_fault_d = align_fault_q | fault;
    end

    always_ff @(posedge clk) begin
        if (reset) align_fault_q <= 1'b0;
        else       align_fault_q <= align_fault_d;
    end

    assign align_fault = align_fault_q;
`else
    assign commit = store_req;
`endif

    // Pop before push, so a full FIFO can still take a store while draining.
    always_comb begin
        fifo_pop     = !fifo_empty && trace_ready;
        drop         = commit && fifo_full && !fifo_pop;
        fifo_push    = commit && !drop;
        ovf_d        = ovf_q;
        if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
        entry.pc     = m_inst_addr;
        entry.addr   = {m_data_addr[31:2], 2'b00};
        entry.data   = merged;
        entry.byteen = m_data_byteen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            ovf_q <= '0;
        end else begin
            if (commit) mem_q[idx] <= merged;
            ovf_q <= ovf_d;
        end
    end

    trace_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trace_valid  = !fifo_empty;
    assign trace_pc     = head[TE_PC_LSB   +: 32];
    assign trace_addr   = head[TE_ADDR_LSB +: 32];
    assign trace_data   = head[TE_DATA_LSB +: 32];
    assign trace_byteen = head[TE_BE_LSB   +: 4];
    assign trace_ovf    = ovf_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed table plus random traffic,
// both compared against a behavioural memory/queue model.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        trace_valid, trace_ready;
    logic [31:0] trace_pc, trace_addr, trace_data;
    logic [3:0]  trace_byteen;
    logic [7:0]  trace_ovf;
`ifdef DM_ALIGN_CHECK_EN
    logic        align_fault;
    bit          m_fault;
`endif

    always #5 clk = ~clk;

    dm_responder dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_byteen  (trace_byteen),
`ifdef DM_ALIGN_CHECK_EN
        .align_fault   (align_fault),
`endif
        .trace_ovf     (trace_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: word array, queue of trace entries, drop counter.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mm [0:3071];
    int          m_ovf;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
        bit          rdy;
        logic [31:0] e_rdata;
        bit          e_valid;
        int          e_ovf;
    } row_t;

    row_t rows[$];

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [11:0] w;
        w = a[13:2];
        if (a < 32'h3000) return mm[w];
        return 32'h0;
    endfunction

    function automatic bit m_legal(input logic [3:0] be, input logic [1:0] lo);
        int sh;
        sh = int'(lo);
        if (be == 4'hF) return lo == 2'd0;
        if (be == 4'h3) return lo == 2'd0;
        if (be == 4'hC) return lo == 2'd2;
        return int'(be) == (1 << sh);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3072; i++) mm[i] = 32'h0;
        mq.delete();
        m_ovf = 0;
`ifdef DM_ALIGN_CHECK_EN
        m_fault = 1'b0;
`endif
    endtask

    // One bus cycle: drive, check at negedge, then advance the model at posedge.
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                            input logic [31:0] pc, input bit rdy,
                            input bit has_exp, input logic [31:0] e_rdata,
                            input bit e_valid, input int e_ovf);
        logic [31:0] merged, old;
        logic [11:0] wi;
        bit          commit;
        m_data_addr   = a;
        m_data_wdata  = w;
        m_data_byteen = be;
        m_inst_addr   = pc;
        trace_ready   = rdy;
        @(negedge clk);
        chk("rdata", 100'(m_data_rdata), 100'(m_read(a)));
        chk("valid", 100'(trace_valid), 100'(mq.size() != 0));
        chk("ovf", 100'(trace_ovf), 100'(m_ovf));
        if (mq.size() != 0)
            chk("head", {trace_pc, trace_addr, trace_data, trace_byteen},
                {mq[0].pc, mq[0].addr, mq[0].data, mq[0].be});
`ifdef DM_ALIGN_CHECK_EN
        chk("align_fault", 100'(align_fault), 100'(m_fault));
`endif
        if (has_exp) begin
            chk("tbl_rdata", 100'(m_data_rdata), 100'(e_rdata));
            chk("tbl_valid", 100'(trace_valid), 100'(e_valid));
            chk("tbl_ovf", 100'(trace_ovf), 100'(e_ovf));
        end
        @(posedge clk);
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        commit = (be != 4'h0) && (a < 32'h3000);
`ifdef DM_ALIGN_CHECK_EN
        if (commit && !m_legal(be, a[1:0])) begin
            commit  = 1'b0;
            m_fault = 1'b1;
        end
`endif
        if (commit) begin
            old = m_read(a);
            merged = old;
            for (int k = 0; k < 4; k++)
                if (be[k]) merged[8*k +: 8] = w[8*k +: 8];
            wi = a[13:2];
            mm[wi] = merged;
            if (mq.size() < 8) mq.push_back('{pc, {a[31:2], 2'b00}, merged, be});
            else if (m_ovf < 255) m_ovf++;
        end
        #1;
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       input logic [31:0] pc, input bit rdy, input logic [31:0] er,
                       input bit ev, input int eo);
        rows.push_back('{a, w, be, pc, rdy, er, ev, eo});
    endtask

    initial begin
        logic [31:0] ra;
        reset = 1'b1;
        m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0; m_inst_addr = 0;
        trace_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        add(32'h0,    0, 4'h0, 0, 0, 32'h0, 0, 0);
        add(32'h2FFC, 0, 4'h0, 0, 0, 32'h0, 0, 0);
        add(32'h100, 32'h12345678, 4'hF, 32'h3000, 0, 32'h0, 0, 0);
        add(32'h100, 0, 4'h0, 0, 0, 32'h12345678, 1, 0);
        add(32'h101, 32'h0000AB00, 4'h2, 32'h3004, 0, 32'h12345678, 1, 0);
        add(32'h102, 32'hBEEF0000, 4'hC, 32'h3008, 0, 32'h1234AB78, 1, 0);
        add(32'h100, 0, 4'h0, 0, 1, 32'hBEEFAB78, 1, 0);
        add(32'h100, 0, 4'h0, 0, 1, 32'hBEEFAB78, 1, 0);
        add(32'h100, 0, 4'h0, 0, 1, 32'hBEEFAB78, 1, 0);
        add(32'h100, 0, 4'h0, 0, 1, 32'hBEEFAB78, 0, 0);
        add(32'h200, 32'h11111111, 4'hF, 32'h3100, 1, 32'h0, 0, 0);
        add(32'h200, 32'h22222222, 4'hF, 32'h3104, 1, 32'h11111111, 1, 0);
        add(32'h200, 0, 4'h0, 0, 1, 32'h22222222, 1, 0);
        add(32'h200, 0, 4'h0, 0, 0, 32'h22222222, 0, 0);
        for (int i = 0; i < 10; i++)
            add(32'h300 + 32'(4*i), 32'(i+1), 4'hF, 32'h3200 + 32'(4*i), 0,
                32'h0, i != 0, (i == 9) ? 1 : 0);
        for (int i = 0; i < 3; i++)
            add(32'h400 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 32'h3300, 1, 32'h0, 1, 2);
        add(32'h3000, 32'hDEADBEEF, 4'hF, 32'h3400, 0, 32'h0, 1, 2);
        add(32'h3000, 0, 4'h0, 0, 0, 32'h0, 1, 2);
        add(32'h0,    0, 4'h0, 0, 0, 32'h0, 1, 2);

        foreach (rows[i])
            do_cycle(rows[i].addr, rows[i].wdata, rows[i].be, rows[i].pc, rows[i].rdy,
                     1'b1, rows[i].e_rdata, rows[i].e_valid, rows[i].e_ovf);

        // Random traffic over a small window plus out-of-range addresses.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0)
                ra = 32'h2FF8 + 32'($urandom_range(0, 15));
            else
                ra = 32'($urandom_range(0, 63));
            do_cycle(ra, $urandom, 4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 9) < 4, 1'b0, 32'h0, 1'b0, 0);
        end

`ifdef DM_ALIGN_CHECK_EN
        do_cycle(32'h102, 32'h000000FF, 4'h1, 32'h3500, 0, 1'b0, 32'h0, 1'b0, 0);
        do_cycle(32'h100, 0, 4'h0, 0, 0, 1'b0, 32'h0, 1'b0, 0);
        chk("fault_nowrite", 100'(m_data_rdata), 100'(32'hBEEFAB78));
        chk("fault_sticky", 100'(align_fault), 100'(1));
`endif

        // Reset with a concurrent store and pop: reset must win.
        m_data_addr = 32'h0; m_data_wdata = 32'hFFFFFFFF; m_data_byteen = 4'hF;
        trace_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        do_cycle(32'h100, 0, 4'h0, 0, 1, 1'b1, 32'h0, 1'b0, 0);
        do_cycle(32'h0,   0, 4'h0, 0, 0, 1'b1, 32'h0, 1'b0, 0);
        chk("rst_trace_data", {trace_pc, trace_addr, trace_data, trace_byteen}, 100'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the P6 pipelined CPU's external data bus. It is the memory end of the CPU's m_data_* interface.
- Services byte-enabled stores and returns load words combinationally in the same cycle, which is the timing the CPU's ext_DM load path expects.
- Logs every committed store (PC, address, merged word, byteen) into a trace FIFO, drained over a valid/ready handshake by the trace/checker consumer.

Parameters:
- MEM_WORDS, 3072: words of storage (byte range 0x0000–0x2FFF).
- TRACE_DEPTH, 8: trace FIFO entries; power of two.
- OVF_W, 8: width of the saturating dropped-trace counter.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  synchronous, active-high reset.
- m_data_addr  in  32  byte address from the CPU M stage.
- m_data_wdata  in  32  store data, already lane-shifted by the CPU.
- m_data_byteen  in  4  byte write enables; 0 means no store.
- m_inst_addr  in  32  PC of the M-stage instruction.
- m_data_rdata  out  32  load word for word address m_data_addr[31:2].
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts the head this cycle.
- trace_pc  out  32  head: store PC.
- trace_addr  out  32  head: word-aligned address, {addr[31:2],2'b00}.
- trace_data  out  32  head: full word after the merge.
- trace_byteen  out  4  head: byteen used.
- trace_ovf  out  OVF_W  count of stores dropped because the FIFO was full.

Behaviour:
- Reset (sync, active-high, one cycle):
  - All MEM_WORDS words cleared to 0.
  - FIFO emptied; trace_valid=0; trace_* outputs 0; trace_ovf=0.
  - Reset dominates any store or pop in the same cycle.
- Word index is m_data_addr[13:2]. An address is in range iff m_data_addr < MEM_WORDS*4.
- Read path:
  - m_data_rdata = mem[index], combinational, with zero latency.
  - It shows contents before any same-cycle store (read-before-write).
  - Out-of-range address reads 0.
- Store: when byteen!=0, the address is in range, and reset=0, at posedge mem[index] byte lane k takes wdata[8k+7:8k] for each byteen[k]=1. Other lanes are unchanged.
- Store with byteen!=0 to an out-of-range address: no memory write, no trace entry.
- Trace push:
  - Each committed store pushes one entry in the same edge.
  - Entry fields: pc=m_inst_addr, addr=word-aligned address, data=merged word (old lanes OR new lanes), byteen.
- FIFO:
  - Show-ahead: the head appears on trace_* while trace_valid=1.
  - Pop occurs when trace_valid & trace_ready.
  - Latency: a push is visible on trace_valid on the next cycle when the FIFO was empty.
  - Empty and trace_ready=1: no pop; outputs hold.
  - Full with a simultaneous pop and push: both happen and the count stays full.
  - Full with a push and no pop: entry dropped; trace_ovf increments, saturating at all-ones.
  - Pointers wrap modulo TRACE_DEPTH. Full/empty are tracked with an extra pointer bit.
- Back-to-back stores to the same word: each cycle merges onto the previous cycle's committed value. Each trace entry shows the cumulative word.
- The CPU is never stalled; this block has no ready output toward the CPU.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined:
  - A store whose byteen is not one of 1111 with addr[1:0]=00, 0011/1100 with addr[1:0]=00/10, or a single one-hot lane equal to 1<<addr[1:0] is a fault.
  - A fault suppresses both the memory write and the trace push.
  - Extra output port align_fault (1 bit), sticky, set on the faulting edge, cleared only by reset.
- Undefined:
  - No port, no check.
  - Any nonzero byteen is written as given.

Decomposition:
- Package dm_pkg holds:
  - MEM_BYTES constant (0x3000).
  - BE_WORD/BE_HALF_LO/BE_HALF_HI constants.
  - TRACE_ENTRY_W = 100 (32+32+32+4).
  - Field offsets of the packed trace entry.
- One sub-module, trace_fifo:
  - Parameterised by width and depth.
  - Push, pop, full, empty, show-ahead head.
  - dm_responder instantiates it and owns the drop/overflow logic.

Test Plan:
- Reset, then read addr 0x0 and 0x2FFC -> rdata=0x00000000; trace_valid=0; trace_ovf=0.
- sw 0x12345678 @0x100 (be=1111, pc=0x3000), then read 0x100 -> rdata=0x12345678. Trace head: pc=0x3000, addr=0x100, data=0x12345678, be=1111.
- Byte and half stores to the same word on consecutive cycles:
  - Stimulus: sb wdata 0x0000AB00 be=0010 @0x101, then sh wdata 0xBEEF0000 be=1100 @0x102.
  - Required: word=0xBEEFAB78.
  - Required: trace entries show data 0x1234AB78, then 0xBEEFAB78.
- Same-cycle read/write at 0x200 (old 0x11111111, store 0x22222222) -> rdata=0x11111111 that cycle and 0x22222222 the next.
- Hold trace_ready=0 and issue 10 stores -> 8 entries kept, trace_ovf=2. Then raise ready while storing every cycle -> full stays full, no further drops.
- Store to 0x3000 -> memory unchanged, no trace entry. With DM_ALIGN_CHECK_EN: be=0001 @0x102 -> no write, align_fault=1 until reset.
